program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Sequences the program ROM through a multi-cycle datapath.
- Walks ROM addresses 0..PROG_LEN-1 and splits each 16-bit word into nibbles a, b, c, d.
- Computes W_q = (a + d) * b - c on a single shared accumulator. The multiply is done by repeated addition.
- Presents each result on a valid/ready output port. Sits between Program_Rom and the result consumer (display/checker).

Parameters:
- PROG_LEN, 4, number of ROM entries executed per run (1..16).
- RESULT_W, 10, signed two's-complement width of W_q. Must cover -15..450.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to run the program; sampled only in IDLE.
- rom_addr  output  4  address to Program_Rom.
- rom_data  input  16  combinational ROM data for rom_addr.
- wq_valid  output  1  result available.
- wq_ready  input  1  consumer accepts the result when wq_valid && wq_ready.
- wq_data  output  RESULT_W  signed W_q.
- wq_index  output  4  ROM address that produced wq_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE; pc=0, rom_addr=0, acc=0, cnt=0; wq_valid=0, wq_data=0, wq_index=0, busy=0, done=0. Takes effect immediately, including mid-operation. Any in-flight result is discarded.
- Field decode: a=rom_data[3:0], b=[7:4], c=[11:8], d=[15:12]. All fields are unsigned.
- rom_addr = pc at all times, so the ROM is read combinationally.
- FSM states: IDLE, FETCH, ADD, MUL, SUB, OUT, DONE.
  - IDLE: if start, set pc<=0 and go to FETCH. Otherwise stay.
  - FETCH: latch a, b, c, d from rom_data; acc<=0; go to ADD.
  - ADD: sum<=a+d (5 bits); cnt<=b; go to MUL.
  - MUL, when cnt==0: leave acc unchanged and go to SUB. This takes 1 cycle, so b=0 yields 0.
  - MUL, otherwise: acc<=acc+sum and cnt<=cnt-1. Move to SUB on the cycle cnt reaches 0. Total of max(b,1) cycles in MUL.
  - SUB: acc<=acc-c (signed RESULT_W); go to OUT.
  - OUT: wq_valid=1, wq_data=acc, wq_index=pc. These values are held stable until the handshake.
    - On handshake with pc==PROG_LEN-1: go to DONE.
    - On handshake otherwise: pc<=pc+1 and go to FETCH.
  - DONE: done=1 for exactly one cycle; pc<=0; go to IDLE.
- Latency: wq_valid rises 3+max(b,1) clock edges after the edge that samples start (or after the previous handshake). Example: b=3 gives 6.
- Backpressure: while wq_ready=0 in OUT, everything holds. No further fetch happens.
- wq_valid is 0 in every state except OUT.
- start asserted while busy is ignored; it is neither queued nor restarts the run.
- start and done are never in the same cycle. Because done lasts one cycle in DONE, start is accepted at the earliest in the following IDLE cycle.
- Arithmetic is exact for all 4-bit inputs, since -15 <= W_q <= 450 fits in RESULT_W=10. No saturation.
- pc wraps only through DONE; it never exceeds PROG_LEN-1.

Decomposition:
- Package program_sequencer_pkg holds:
  - enum state_e {IDLE, FETCH, ADD, MUL, SUB, OUT, DONE}
  - packed struct instr_t {d, c, b, a} (4 bits each, MSB first), overlaying the ROM word
  - localparam NIB_W=4
- Optional sub-module seq_mul_acc: the repeated-add multiplier (load/sum/cnt/busy). All remaining logic is one FSM in program_sequencer.

Test Plan:
- Nominal run, standard ROM, wq_ready=1: start -> results (0,13), (1,29), (2,33), (3,63), then one done pulse and busy falls. Entry 0 wq_valid is 6 edges after start.
- Backpressure: hold wq_ready=0 for 10 cycles during entry 1 -> wq_data=29 and wq_index=1 stay stable, rom_addr stays 1, no done. Release -> entries 2 and 3 follow normally.
- b=0 edge: bench ROM entry 0 = 16'h0F0F (a=15, b=0, c=15, d=0), PROG_LEN=1 -> W_q=-15 (10'h3F1), valid 4 edges after start.
- Max value: ROM entry 0 = 16'hF0FF (a=15, b=15, c=0, d=15) -> W_q=450, valid 18 edges after start.
- Start while busy: pulse start during entry 1 MUL -> ignored, sequence identical to nominal.
- Async reset mid-MUL of entry 2: outputs clear immediately without waiting for a clock edge. A fresh start reproduces 13, 29, 33, 63 from index 0.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_pkg
// Description : Shared types and helpers for the program sequencer.
//               - state_e : sequencer FSM states (explicit 3-bit encoding)
//               - instr_t : ROM word overlay, nibbles d|c|b|a (MSB first)
//               - NIB_W   : width of a single instruction field
//               - nib_sum : 4-bit + 4-bit unsigned add with carry out
// Revision    : 1.0 - initial release
// ============================================================================
package program_sequencer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ADD   = 3'd2,
        MUL   = 3'd3,
        SUB   = 3'd4,
        OUT   = 3'd5,
        DONE  = 3'd6
    } state_e;

    // Overlays the 16-bit ROM word: d = [15:12], c = [11:8], b = [7:4], a = [3:0].
    typedef struct packed {
        logic [NIB_W-1:0] d;
        logic [NIB_W-1:0] c;
        logic [NIB_W-1:0] b;
        logic [NIB_W-1:0] a;
    } instr_t;

    // Unsigned nibble sum kept one bit wider so a + d never overflows.
    function automatic logic [NIB_W:0] nib_sum(input logic [NIB_W-1:0] x,
                                               input logic [NIB_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_if
// Description : Valid/ready result port carrying W_q and the ROM index that
//               produced it.
//               Signals : wq_valid, wq_ready, wq_data[RESULT_W], wq_index[4]
//               master  : producer (drives valid/data/index, samples ready)
//               slave   : consumer (drives ready, samples the rest)
// Revision    : 1.0 - initial release
// ============================================================================
interface program_sequencer_if #(
    parameter int RESULT_W = 10
);
    logic                wq_valid;
    logic                wq_ready;
    logic [RESULT_W-1:0] wq_data;
    logic [3:0]          wq_index;

    modport master (
        output wq_valid,
        output wq_data,
        output wq_index,
        input  wq_ready
    );

    modport slave (
        input  wq_valid,
        input  wq_data,
        input  wq_index,
        output wq_ready
    );
endinterface
`default_nettype wire

// File: rtl/seq_mul_acc.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_acc
// Description : Shared accumulator datapath for W = (a + d) * b - c.
//               The multiply is repeated addition of (a + d), b times.
//               Ports:
//                 clk, rst      : clock, async active-high reset
//                 clr_i         : acc <= 0
//                 setup_i       : sum <= a + d, cnt <= b
//                 step_i        : one multiply step (acc += sum, cnt -= 1)
//                 sub_i         : acc <= acc - c
//                 instr_i       : latched instruction fields
//                 acc_o         : current accumulator
//                 acc_sub_o     : acc - c (value acc takes on sub_i)
//                 last_o        : the current step is the final MUL cycle
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_acc
    import program_sequencer_pkg::*;
#(
    parameter int RESULT_W = 10
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                clr_i,
    input  wire logic                setup_i,
    input  wire logic                step_i,
    input  wire logic                sub_i,
    input  wire instr_t              instr_i,
    output logic [RESULT_W-1:0]      acc_o,
    output logic [RESULT_W-1:0]      acc_sub_o,
    output logic                     last_o
);

    localparam logic [NIB_W-1:0] c_NIB_ONE = NIB_W'(1);

    logic [RESULT_W-1:0] acc_q;
    logic [NIB_W:0]      sum_q;
    logic [NIB_W-1:0]    cnt_q;
    logic [RESULT_W-1:0] acc_sub_d;

    // Two's-complement subtraction; the bit pattern is the signed result.
    assign acc_sub_d = acc_q - RESULT_W'(instr_i.c);

    assign acc_o     = acc_q;
    assign acc_sub_o = acc_sub_d;
    // cnt == 0 (b = 0) still costs one MUL cycle; cnt == 1 is the final add.
    assign last_o    = (cnt_q <= c_NIB_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            if (clr_i) begin
                acc_q <= '0;
            end
            if (setup_i) begin
                sum_q <= nib_sum(instr_i.a, instr_i.d);
                cnt_q <= instr_i.b;
            end
            if (step_i && (cnt_q != '0)) begin
                acc_q <= acc_q + RESULT_W'(sum_q);
                cnt_q <= cnt_q - c_NIB_ONE;
            end
            if (sub_i) begin
                acc_q <= acc_sub_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer
// Description : Walks Program_Rom entries 0..PROG_LEN-1, decodes each word
//               into nibbles a/b/c/d and computes W = (a + d) * b - c on a
//               shared accumulator, presenting each result on a valid/ready
//               port together with its ROM index.
//               Ports:
//                 clk, rst    : clock, async active-high reset
//                 start_i     : run request, honoured only in IDLE
//                 rom_addr_o  : ROM address (equals pc)
//                 rom_data_i  : combinational ROM data
//                 wq          : result port (master side)
//                 busy_o      : high whenever not IDLE
//                 done_o      : one-cycle pulse after the last handshake
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PROG_LEN = 4,
    parameter int RESULT_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start_i,
    output logic [3:0]       rom_addr_o,
    input  wire logic [15:0] rom_data_i,
    program_sequencer_if.master wq,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] c_LAST_PC = 4'(PROG_LEN - 1);
    localparam logic [3:0] c_PC_ONE  = 4'd1;

    state_e              state_q;
    logic [3:0]          pc_q;
    instr_t              instr_q;
    logic                wq_valid_q;
    logic [RESULT_W-1:0] wq_data_q;
    logic [3:0]          wq_index_q;
    logic                busy_q;
    logic                done_q;

    logic                w_clr;
    logic                w_setup;
    logic                w_step;
    logic                w_sub;
    logic                w_mul_last;
    logic [RESULT_W-1:0] w_acc;
    logic [RESULT_W-1:0] w_acc_sub;

    // Datapath strobes follow the FSM state directly.
    assign w_clr   = (state_q == FETCH);
    assign w_setup = (state_q == ADD);
    assign w_step  = (state_q == MUL);
    assign w_sub   = (state_q == SUB);

    seq_mul_acc #(
        .RESULT_W (RESULT_W)
    ) u_mul_acc (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_clr),
        .setup_i   (w_setup),
        .step_i    (w_step),
        .sub_i     (w_sub),
        .instr_i   (instr_q),
        .acc_o     (w_acc),
        .acc_sub_o (w_acc_sub),
        .last_o    (w_mul_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            wq_valid_q <= 1'b0;
            wq_data_q  <= '0;
            wq_index_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    instr_q <= instr_t'(rom_data_i);
                    state_q <= ADD;
                end
                ADD: begin
                    state_q <= MUL;
                end
                MUL: begin
                    if (w_mul_last) begin
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    // Capture the post-subtract value so the output is
                    // registered and valid on the first OUT cycle.
                    wq_valid_q <= 1'b1;
                    wq_data_q  <= w_acc_sub;
                    wq_index_q <= pc_q;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (wq.wq_ready) begin
                        wq_valid_q <= 1'b0;
                        if (pc_q == c_LAST_PC) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            pc_q    <= pc_q + c_PC_ONE;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    pc_q    <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The accumulator value is only consumed through the SUB capture.
    logic w_acc_unused;
    assign w_acc_unused = ^w_acc;

    assign rom_addr_o  = pc_q;
    assign wq.wq_valid = wq_valid_q;
    assign wq.wq_data  = wq_data_q;
    assign wq.wq_index = wq_index_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer
// Description : Self-checking bench for program_sequencer. A behavioural
//               model computes W = (a + d) * b - c and the expected latency
//               from each ROM word; directed and random runs are compared
//               against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

    localparam int PROG_LEN = 4;
    localparam int RESULT_W = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;

    logic [15:0] rom_mem [16];
    logic [9:0]  res_data [PROG_LEN];
    logic [9:0]  nom_vals [PROG_LEN];
    logic [9:0]  exp_neg;
    logic [9:0]  exp_max;
    int          total = 0;
    int          bad = 0;

    program_sequencer_if #(.RESULT_W(RESULT_W)) wq_if ();

    assign rom_data = rom_mem[rom_addr];

    always #5 clk = ~clk;

    program_sequencer #(
        .PROG_LEN (PROG_LEN),
        .RESULT_W (RESULT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .wq         (wq_if.master),
        .busy_o     (busy),
        .done_o     (done)
    );

    // Reference: plain integer arithmetic on the decoded fields.
    function automatic logic [9:0] model_w(input logic [15:0] w);
        int a, b, c, d;
        a = int'(w[3:0]);
        b = int'(w[7:4]);
        c = int'(w[11:8]);
        d = int'(w[15:12]);
        return 10'((a + d) * b - c);
    endfunction

    function automatic int model_lat(input logic [15:0] w);
        int b;
        b = int'(w[7:4]);
        return 3 + ((b == 0) ? 1 : b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_std();
        rom_mem[0] = 16'h3232;   // (2+3)*3-2 = 13
        rom_mem[1] = 16'h4653;   // (3+4)*5-6 = 29
        rom_mem[2] = 16'h5344;   // (4+5)*4-3 = 33
        rom_mem[3] = 16'h8772;   // (2+8)*7-7 = 63
    endtask

    // One program run. hold_entry/poke_entry/abort_entry < 0 disables them.
    task automatic run_prog(input bit rnd_ready, input int hold_entry, input int hold_cycles,
                            input int poke_entry, input int abort_entry);
        int         lat;
        int         k;
        bit         aborted;
        logic [9:0] hd;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < PROG_LEN; i++) begin
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
                start = (i == poke_entry && lat == 3);
                if (i == abort_entry && lat == 4) begin
                    rst = 1'b1;
                    #1;
                    check("abort_busy", busy, 0);
                    check("abort_valid", wq_if.wq_valid, 0);
                    check("abort_data", wq_if.wq_data, 0);
                    check("abort_index", wq_if.wq_index, 0);
                    check("abort_rom_addr", rom_addr, 0);
                    check("abort_done", done, 0);
                    aborted = 1'b1;
                end
            end while (!aborted && !wq_if.wq_valid && lat < 100);
            start = 1'b0;
            if (aborted) break;
            check("latency", lat, model_lat(rom_mem[i]));
            check("data", wq_if.wq_data, model_w(rom_mem[i]));
            check("index", wq_if.wq_index, i);
            check("busy_run", busy, 1);
            res_data[i] = wq_if.wq_data;
            hd = wq_if.wq_data;
            k = (i == hold_entry) ? hold_cycles : (rnd_ready ? int'($urandom_range(0, 3)) : 0);
            for (int j = 0; j < k; j++) begin
                @(posedge clk); #1;
                check("hold_valid", wq_if.wq_valid, 1);
                check("hold_data", wq_if.wq_data, hd);
                check("hold_index", wq_if.wq_index, i);
                check("hold_rom_addr", rom_addr, i);
                check("hold_done", done, 0);
            end
            wq_if.wq_ready = 1'b1;
            @(posedge clk); #1;
            wq_if.wq_ready = 1'b0;
            check("post_hs_valid", wq_if.wq_valid, 0);
            check("done_pulse", done, (i == PROG_LEN - 1));
        end
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
        end else begin
            @(posedge clk); #1;
            check("done_fall", done, 0);
            check("busy_fall", busy, 0);
            check("idle_rom_addr", rom_addr, 0);
        end
    endtask

    initial begin
        wq_if.wq_ready = 1'b0;
        nom_vals[0] = 10'd13;
        nom_vals[1] = 10'd29;
        nom_vals[2] = 10'd33;
        nom_vals[3] = 10'd63;
        exp_neg     = 10'h3F1;
        exp_max     = 10'd450;
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'h0000;
        load_std();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", wq_if.wq_valid, 0);
        check("rst_data", wq_if.wq_data, 0);
        check("rst_index", wq_if.wq_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start_busy", busy, 0);

        // Nominal run
        run_prog(1'b0, -1, 0, -1, -1);
        for (int i = 0; i < PROG_LEN; i++) check("nominal_value", res_data[i], nom_vals[i]);

        // Backpressure on entry 1 for 10 cycles
        run_prog(1'b0, 1, 10, -1, -1);
        for (int i = 0; i < PROG_LEN; i++) check("bp_value", res_data[i], nom_vals[i]);

        // Start pulsed while busy during entry 1 MUL
        run_prog(1'b0, -1, 0, 1, -1);
        for (int i = 0; i < PROG_LEN; i++) check("poke_value", res_data[i], nom_vals[i]);

        // b = 0 edge
        rom_mem[0] = 16'h0F0F;
        run_prog(1'b0, -1, 0, -1, -1);
        check("b0_value", res_data[0], exp_neg);

        // Maximum result
        rom_mem[0] = 16'hF0FF;
        run_prog(1'b0, -1, 0, -1, -1);
        check("max_value", res_data[0], exp_max);

        // Async reset mid-MUL of entry 2, then a clean rerun
        load_std();
        run_prog(1'b0, -1, 0, -1, 2);
        run_prog(1'b0, -1, 0, -1, -1);
        for (int i = 0; i < PROG_LEN; i++) check("rerun_value", res_data[i], nom_vals[i]);

        // Random ROM contents with random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < PROG_LEN; i++) rom_mem[i] = 16'($urandom);
            run_prog(1'b1, -1, 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
